// File: rtl/addsub_ctrl_pkg.sv
// Shared constants and state encoding for the add/sub arbiter.
package addsub_ctrl_pkg;

  // Operand width of the shared adder/subtractor.
  localparam int unsigned OPW = 4;

  // Operation select encoding.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_subtractor_4bit.sv
// Combinational 4-bit adder/subtractor: sel=0 -> a+b, sel=1 -> a+~b+1.
// cout is bit 4 of the 5-bit result (for subtract, 1 means no borrow).
module adder_subtractor_4bit
  import addsub_ctrl_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           sel,
  output logic [OPW-1:0] sum,
  output logic           cout
);

  logic [OPW-1:0] b_eff;
  logic [OPW:0]   total;

  // Invert B and inject the carry-in for subtraction.
  always_comb begin
    b_eff = (sel == OP_SUB) ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{OPW{1'b0}}, sel};
  end

  assign sum  = total[OPW-1:0];
  assign cout = total[OPW];

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a single shared adder_subtractor_4bit.
// A granted operation is latched, given SETTLE_CYCLES cycles to settle, captured,
// and held on the rsp_* outputs until the consumer takes it.
// Optional feature: define ADDSUB_OVF_FLAG_EN to add the rsp_ovf output
// (signed overflow of the captured operation).
module addsub_arbiter
  import addsub_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic           req_valid_0,
  output logic           req_ready_0,
  input  logic [OPW-1:0] req_a_0,
  input  logic [OPW-1:0] req_b_0,
  input  logic           req_sel_0,

  input  logic           req_valid_1,
  output logic           req_ready_1,
  input  logic [OPW-1:0] req_a_1,
  input  logic [OPW-1:0] req_b_1,
  input  logic           req_sel_1,

  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [OPW-1:0] rsp_sum,
  output logic           rsp_cout,
`ifdef ADDSUB_OVF_FLAG_EN
  output logic           rsp_ovf,
`endif
  output logic           busy
);

  // Final EXEC count value; EXEC spans counts 0 .. SETTLE_CYCLES-1.
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_e         state;
  logic           last_served;  // requester granted most recently
  logic [3:0]     settle_cnt;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic           op_sel;
  logic           op_id;
  logic           grant_0;
  logic           grant_1;
  logic [OPW-1:0] add_sum;
  logic           add_cout;

  // Round-robin grant, only offered while idle; on a tie the requester not
  // served last wins.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (state == IDLE) begin
      if (req_valid_0 && (!req_valid_1 || last_served)) begin
        grant_0 = 1'b1;
      end else if (req_valid_1) begin
        grant_1 = 1'b1;
      end
    end
  end

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  // Latched operands drive the shared datapath, so requester inputs that
  // change after the grant cannot disturb the operation in flight.
  adder_subtractor_4bit u_addsub (
    .a    (op_a),
    .b    (op_b),
    .sel  (op_sel),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef ADDSUB_OVF_FLAG_EN
  logic b_msb_eff;
  logic ovf_calc;

  // Signed overflow: effective operands share a sign that the result lacks.
  always_comb begin
    b_msb_eff = (op_sel == OP_SUB) ? ~op_b[OPW-1] : op_b[OPW-1];
    ovf_calc  = (op_a[OPW-1] == b_msb_eff) && (add_sum[OPW-1] != op_a[OPW-1]);
  end
`endif

  // Control FSM with registered response and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      settle_cnt  <= 4'd0;
      op_a        <= '0;
      op_b        <= '0;
      op_sel      <= OP_ADD;
      op_id       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_sum     <= '0;
      rsp_cout    <= 1'b0;
      busy        <= 1'b0;
`ifdef ADDSUB_OVF_FLAG_EN
      rsp_ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_0 || grant_1) begin
            op_a        <= grant_1 ? req_a_1 : req_a_0;
            op_b        <= grant_1 ? req_b_1 : req_b_0;
            op_sel      <= grant_1 ? req_sel_1 : req_sel_0;
            op_id       <= grant_1;
            last_served <= grant_1;
            settle_cnt  <= 4'd0;
            busy        <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (settle_cnt == LAST_CNT) begin
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
`ifdef ADDSUB_OVF_FLAG_EN
            rsp_ovf   <= ovf_calc;
`endif
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        RESP: begin
          // Returning to IDLE here means no new grant in the handshake cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: stimulus threads drive requesters, a
// negedge monitor predicts grants/responses from plain arithmetic and compares.
`timescale 1ns/1ps
module tb_addsub_arbiter;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic       req_ready_0, req_ready_1;
  logic [3:0] req_a_0 = 4'd0, req_b_0 = 4'd0, req_a_1 = 4'd0, req_b_1 = 4'd0;
  logic       req_sel_0 = 1'b0, req_sel_1 = 1'b0;
  logic       rsp_valid, rsp_id, rsp_cout, busy;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_sum;
`ifdef ADDSUB_OVF_FLAG_EN
  logic       rsp_ovf;
`endif

  addsub_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_0 (req_valid_0),
    .req_ready_0 (req_ready_0),
    .req_a_0     (req_a_0),
    .req_b_0     (req_b_0),
    .req_sel_0   (req_sel_0),
    .req_valid_1 (req_valid_1),
    .req_ready_1 (req_ready_1),
    .req_a_1     (req_a_1),
    .req_b_1     (req_b_1),
    .req_sel_1   (req_sel_1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_cout    (rsp_cout),
`ifdef ADDSUB_OVF_FLAG_EN
    .rsp_ovf     (rsp_ovf),
`endif
    .busy        (busy)
  );

  typedef struct {
    int id;
    int sum;
    int cout;
    int ovf;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t got_q[$];
  int   served_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_srv = 1;
  int   busy_m = 0;
  int   last_hs = -1;
  int   last_xfer = -1;
  bit   hold_low = 1'b0;
  bit   rand_rr = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d required=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference result from the arithmetic definition of add/subtract.
  function automatic exp_t model(input int id, input int a, input int b, input int sel);
    exp_t e;
    int raw, sa, sb, sr;
    raw = (sel != 0) ? a + 16 - b : a + b;
    sa  = (a > 7) ? a - 16 : a;
    sb  = (b > 7) ? b - 16 : b;
    sr  = (sel != 0) ? sa - sb : sa + sb;
    e.id   = id;
    e.sum  = raw % 16;
    e.cout = raw / 16;
    e.ovf  = (sr < -8 || sr > 7) ? 1 : 0;
    e.due  = 0;
    return e;
  endfunction

  // Monitor: expected readies, busy and responses each cycle.
  initial begin : monitor
    logic e0, e1;
    int   w, busy_next;
    bit   exp_v;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        e0 = (busy_m == 0) && req_valid_0 && (!req_valid_1 || last_srv == 1);
        e1 = (busy_m == 0) && req_valid_1 && (!req_valid_0 || last_srv == 0);
        check("req_ready_0", 32'(req_ready_0), 32'(e0));
        check("req_ready_1", 32'(req_ready_1), 32'(e1));
        check("busy", 32'(busy), busy_m);
        busy_next = busy_m;
        if ((req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1)) begin
          w = (req_valid_0 && req_ready_0) ? 0 : 1;
          if (w == 0) e = model(0, 32'(req_a_0), 32'(req_b_0), 32'(req_sel_0));
          else        e = model(1, 32'(req_a_1), 32'(req_b_1), 32'(req_sel_1));
          e.due = cyc + S + 1;
          q.push_back(e);
          served_q.push_back(w);
          last_srv  = w;
          last_xfer = cyc;
          busy_next = 1;
        end
        exp_v = (q.size() > 0) && (cyc >= q[0].due);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
          check("rsp_id", 32'(rsp_id), q[0].id);
          check("rsp_sum", 32'(rsp_sum), q[0].sum);
          check("rsp_cout", 32'(rsp_cout), q[0].cout);
`ifdef ADDSUB_OVF_FLAG_EN
          check("rsp_ovf", 32'(rsp_ovf), q[0].ovf);
`endif
          if (rsp_ready) begin
            got_q.push_back(q.pop_front());
            last_hs   = cyc;
            busy_next = 0;
          end
        end
        busy_m = busy_next;
      end
    end
  end

  // Consumer side.
  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = hold_low ? 1'b0 : (rand_rr ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  task automatic drive(input int x, input logic [3:0] a, input logic [3:0] b, input logic s);
    if (x == 0) begin
      req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_sel_0 = s;
    end else begin
      req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_sel_1 = s;
    end
  endtask

  task automatic release_req(input int x);
    if (x == 0) req_valid_0 = 1'b0;
    else        req_valid_1 = 1'b0;
  endtask

  // Present an operation and hold it until granted; returns just after the transfer edge.
  task automatic issue(input int x, input logic [3:0] a, input logic [3:0] b, input logic s);
    bit ok = 1'b0;
    drive(x, a, b, s);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((x == 0) ? req_ready_0 : req_ready_1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0 && busy_m == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic churn(input int x);
    if (x == 0) begin
      req_a_0 = 4'($urandom); req_b_0 = 4'($urandom); req_sel_0 = 1'($urandom);
    end else begin
      req_a_1 = 4'($urandom); req_b_1 = 4'($urandom); req_sel_1 = 1'($urandom);
    end
  endtask

  int exp_order[5] = '{0, 1, 0, 1, 0};
  int exp_sum[5]   = '{7, 3, 12, 7, 11};
  int exp_cout[5]  = '{0, 1, 1, 0, 0};
  int exp_ovf[5]   = '{0, 1, 0, 0, 1};

  initial begin : stim
    int  n;
    bit  ok;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    check("reset_rsp_sum", 32'(rsp_sum), 0);
    check("reset_rsp_cout", 32'(rsp_cout), 0);
`ifdef ADDSUB_OVF_FLAG_EN
    check("reset_rsp_ovf", 32'(rsp_ovf), 0);
`endif

    // Contention straight out of reset, carrying the directed vectors.
    rst_n = 1'b1;
    fork
      begin
        issue(0, 4'b0011, 4'b0100, 1'b0);
        issue(0, 4'b1101, 4'b1111, 1'b0);
        issue(0, 4'b0100, 4'b0111, 1'b0);
        release_req(0);
      end
      begin
        issue(1, 4'b1000, 4'b0101, 1'b1);
        issue(1, 4'b0011, 4'b1100, 1'b1);
        release_req(1);
      end
    join
    wait_drain();
    check("contention_count", served_q.size(), 5);
    check("vector_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < served_q.size()) check("service_order", served_q[i], exp_order[i]);
      if (i < got_q.size()) begin
        check("vec_id", got_q[i].id, exp_order[i]);
        check("vec_sum", got_q[i].sum, exp_sum[i]);
        check("vec_cout", got_q[i].cout, exp_cout[i]);
        check("vec_ovf", got_q[i].ovf, exp_ovf[i]);
      end
    end

    // Backpressure: consumer stalls, requester 1 waits behind it.
    hold_low = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue(0, 4'b0101, 4'b0110, 1'b0);
    release_req(0);
    drive(1, 4'b1001, 4'b0010, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_rsp_seen", 32'(ok), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(rsp_valid), 1);
      check("bp_sum_held", 32'(rsp_sum), 11);
      check("bp_id_held", 32'(rsp_id), 0);
      check("bp_ready_0", 32'(req_ready_0), 0);
      check("bp_ready_1", 32'(req_ready_1), 0);
      check("bp_busy", 32'(busy), 1);
    end
    hold_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_1) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_reaccept_seen", 32'(ok), 1);
    @(posedge clk);
    #1;
    release_req(1);
    check("bp_reaccept_cycle", last_xfer, last_hs + 1);
    wait_drain();

    // Reset while the operation is settling.
    issue(0, 4'b0001, 4'b0010, 1'b0);
    release_req(0);
    n = got_q.size();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    q.delete();
    served_q.delete();
    busy_m   = 0;
    last_srv = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fork
      begin issue(0, 4'b0010, 4'b0011, 1'b0); release_req(0); end
      begin issue(1, 4'b0110, 4'b0001, 1'b1); release_req(1); end
    join
    wait_drain();
    check("rst_tie_winner", (served_q.size() > 0) ? served_q[0] : -1, 0);
    check("rst_no_stale_rsp", got_q.size(), n + 2);

    // Randomized traffic with a randomly stalling consumer.
    rand_rr = 1'b1;
    fork
      begin
        for (int i = 0; i < 15; i++) begin
          int gap = $urandom_range(0, 3);
          if (gap > 0) begin
            release_req(0);
            repeat (gap) begin
              churn(0);
              @(posedge clk);
              #1;
            end
          end
          issue(0, 4'($urandom), 4'($urandom), 1'($urandom));
        end
        release_req(0);
      end
      begin
        for (int j = 0; j < 15; j++) begin
          int gap = $urandom_range(0, 3);
          if (gap > 0) begin
            release_req(1);
            repeat (gap) begin
              churn(1);
              @(posedge clk);
              #1;
            end
          end
          issue(1, 4'($urandom), 4'($urandom), 1'($urandom));
        end
        release_req(1);
      end
    join
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, 2, cycles the shared adder_subtractor_4bit is given to settle before capture (legal 1..15).
REQ-002 SHALL have ports (name direction width meaning):
 - clk  in  1  single clock, rising edge.
 - rst_n  in  1  reset, asynchronous, active-low.
 - req_valid_0 / req_valid_1  in  1  requester 0/1 has an operation.
 - req_ready_0 / req_ready_1  out  1  requester 0/1 operation accepted this cycle.
 - req_a_0 / req_a_1  in  4  operand A.
 - req_b_0 / req_b_1  in  4  operand B.
 - req_sel_0 / req_sel_1  in  1  0 = A+B, 1 = A-B.
 - rsp_valid  out  1  result available.
 - rsp_ready  in  1  consumer takes result.
 - rsp_id  out  1  requester the result belongs to.
 - rsp_sum  out  4  result bits.
 - rsp_cout  out  1  carry out (for subtract: 1 = no borrow).
 - busy  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-004 In IDLE, SHALL assert at most one req_ready_x, combinationally, for a valid requester; a transfer occurs when valid && ready in the same cycle.
REQ-005 Arbitration SHALL be round-robin: a sole valid requester wins; on a tie, the requester not served last wins; the last-served pointer updates only on transfer.
REQ-006 On transfer, SHALL register A, B, sel and id, then enter EXEC; the registered operands drive the single adder_subtractor_4bit instance.
REQ-007 EXEC SHALL last exactly SETTLE_CYCLES cycles; on its final cycle sum and cout SHALL be captured into the rsp registers, then the FSM enters RESP.
REQ-008 Latency: transfer in cycle t -> rsp_valid high from cycle t+SETTLE_CYCLES+1 (t+3 at default).
REQ-009 Subtract SHALL be A + ~B + 1, modulo 16; cout is bit 4 of the 5-bit sum.
REQ-010 In RESP, rsp_valid=1 and rsp_id/rsp_sum/rsp_cout SHALL stay stable until rsp_ready=1; that cycle returns the FSM to IDLE, with no new acceptance in the same cycle.
REQ-011 Both req_ready_x SHALL be 0 outside IDLE; requesters hold valid and operands stable until ready.
REQ-012 Operand changes on a non-granted requester SHALL NOT affect an in-flight operation.

Reset
REQ-013 On rst_n low, outputs SHALL immediately become: state=IDLE, rsp_valid=0, busy=0, rsp_id=0, rsp_sum=0, rsp_cout=0; the last-served pointer becomes 1, so requester 0 wins the first tie.
REQ-014 Reset during EXEC or RESP SHALL discard the operation without emitting a response.

Configuration
REQ-015 With ADDSUB_OVF_FLAG_EN defined, SHALL add output rsp_ovf (1 bit), the signed two's-complement overflow of the captured operation, registered and held with the other rsp fields, reset 0.
REQ-016 Without ADDSUB_OVF_FLAG_EN, the port and its logic SHALL be absent and all other behaviour is identical.

Structure
REQ-017 Package addsub_ctrl_pkg SHALL hold OPW=4, OP_ADD=1'b0, OP_SUB=1'b1, and the state enum (IDLE, EXEC, RESP).
REQ-018 SHALL instantiate exactly one existing adder_subtractor_4bit as its sub-module; the arbiter/FSM remains in addsub_arbiter.

Verification
REQ-019 Add: req0 A=0011 B=0100 sel=0 -> transfer at t, rsp_valid at t+3, id=0, sum=0111, cout=0.
REQ-020 Subtract: req1 A=1000 B=0101 sel=1 -> id=1, sum=0011, cout=1; A=0011 B=1100 sel=1 -> sum=0111, cout=0.
REQ-021 Wrap and overflow: A=1101 B=1111 sel=0 -> sum=1100, cout=1, ovf=0; A=0100 B=0111 sel=0 -> sum=1011, cout=0, ovf=1 (when the macro is defined).
REQ-022 Contention: both valid continuously from reset -> service order 0,1,0,1 and rsp_id follows it.
REQ-023 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp fields held stable, both req_ready=0, busy=1; accepts again one cycle after the rsp_ready handshake.
REQ-024 Reset mid-EXEC: rst_n pulsed low -> rsp_valid=0 and busy=0 immediately, no response emitted; on a later tie requester 0 wins.
